// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads a combinational instruction memory and hands
// {instr, pc, pc+4} to decode through a valid/ready slot. Misaligned redirects are sticky faults.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc4,
    output logic        fetch_fault
);

    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("instruction_fetch: RESET_PC must be word aligned");
    end

    typedef enum logic {RUN, FAULT} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        slot_free;

    // Sequential word step; wraps modulo 2^32 without raising a fault.
    function automatic logic [31:0] next_word(input logic [31:0] addr);
        return addr + 32'd4;
    endfunction

    assign imem_addr = pc;
    assign pc_plus4  = next_word(pc);
    assign slot_free = !instr_valid || instr_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            pc          <= RESET_PC;
            instr_valid <= 1'b0;
            instr       <= 32'd0;
            instr_pc    <= 32'd0;
            instr_pc4   <= 32'd0;
            fetch_fault <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
                        state       <= FAULT;
                        fetch_fault <= 1'b1;
                        instr_valid <= 1'b0;
                        pc          <= redirect_pc;
                    end else if (redirect_valid) begin
                        // Flush takes priority over a pending handshake; target is fetched next edge.
                        instr_valid <= 1'b0;
                        pc          <= redirect_pc;
                    end else if (slot_free) begin
                        instr       <= imem_data;
                        instr_pc    <= pc;
                        instr_pc4   <= pc_plus4;
                        instr_valid <= 1'b1;
                        pc          <= pc_plus4;
                    end
                end
                FAULT: begin
                    instr_valid <= 1'b0;
                end
                default: begin
                    state <= FAULT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a randomized run,
// all compared against a behavioural model of the fetch stage.
module tb_instruction_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc4;
    logic        fetch_fault;

    logic [31:0] mem [0:63];

    int vectors;
    int miscompares;

    // Behavioural model state
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic [31:0] m_ipc4;
    logic        m_fault;

    instruction_fetch #(.RESET_PC(32'd0)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_pc4     (instr_pc4),
        .fetch_fault   (fetch_fault)
    );

    assign imem_data = mem[imem_addr[7:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [129:0] dut_vec();
        return {instr_valid, instr, instr_pc, instr_pc4, fetch_fault, imem_addr};
    endfunction

    function automatic logic [129:0] model_vec();
        return {m_valid, m_instr, m_ipc, m_ipc4, m_fault, m_pc};
    endfunction

    task automatic model_reset();
        m_pc    = 32'd0;
        m_valid = 1'b0;
        m_instr = 32'd0;
        m_ipc   = 32'd0;
        m_ipc4  = 32'd0;
        m_fault = 1'b0;
    endtask

    // One rising edge; the model applies the fetch rules to the inputs present at that edge.
    task automatic step();
        logic [31:0] word;
        word = mem[m_pc[7:2]];
        @(posedge clk);
        if (!m_fault) begin
            if (redirect_valid) begin
                m_valid = 1'b0;
                m_pc    = redirect_pc;
                if (redirect_pc % 4 != 0) m_fault = 1'b1;
            end else if (!m_valid || instr_ready) begin
                m_instr = word;
                m_ipc   = m_pc;
                m_ipc4  = m_pc + 32'd4;
                m_valid = 1'b1;
                m_pc    = m_pc + 32'd4;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        instr_ready = 1'b0;
        #7;
        model_reset();
        vectors++;
        if (dut_vec() !== 130'd0) begin
            miscompares++;
            $display("FAIL reset_state: got %h want %h", dut_vec(), 130'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL seq_state[%0d]: got %h want %h", i, dut_vec(), model_vec());
            end
            vectors++;
            if ({instr_valid, instr, instr_pc, instr_pc4} !== {1'b1, mem[i], 32'(4 * i), 32'(4 * i + 4)}) begin
                miscompares++;
                $display("FAIL seq_slot[%0d]: got pc %h instr %h want pc %h instr %h",
                         i, instr_pc, instr, 32'(4 * i), mem[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if ({instr_valid, instr, instr_pc, instr_pc4, imem_addr} !== {1'b1, mem[2], 32'd8, 32'd12, 32'd12}) begin
                miscompares++;
                $display("FAIL backpressure_hold[%0d]: got pc %h instr %h addr %h want pc 8 instr %h addr c",
                         i, instr_pc, instr, imem_addr, mem[2]);
            end
        end
        instr_ready = 1'b1;
        step();
        vectors++;
        if (instr_pc !== 32'd12 || instr !== mem[3] || dut_vec() !== model_vec()) begin
            miscompares++;
            $display("FAIL backpressure_release: got %h want %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_redirect();
        step();
        step();
        vectors++;
        if (instr_pc !== 32'd20 || instr_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL redirect_setup: got pc %h valid %b want pc 14 valid 1", instr_pc, instr_valid);
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'd8;
        step();
        redirect_valid = 1'b0;
        vectors++;
        if (instr_valid !== 1'b0 || imem_addr !== 32'd8 || dut_vec() !== model_vec()) begin
            miscompares++;
            $display("FAIL redirect_bubble: got %h want %h", dut_vec(), model_vec());
        end
        step();
        vectors++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, 32'd8, mem[2]}) begin
            miscompares++;
            $display("FAIL redirect_target: got valid %b pc %h instr %h want 1 8 %h",
                     instr_valid, instr_pc, instr, mem[2]);
        end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        step();
        vectors++;
        if ({instr_valid, instr_pc, instr_pc4, instr, fetch_fault} !== {1'b1, 32'hFFFF_FFFC, 32'd0, mem[63], 1'b0}) begin
            miscompares++;
            $display("FAIL wrap_last: got pc %h pc4 %h instr %h fault %b", instr_pc, instr_pc4, instr, fetch_fault);
        end
        step();
        vectors++;
        if ({instr_valid, instr_pc, instr_pc4, fetch_fault} !== {1'b1, 32'd0, 32'd4, 1'b0}) begin
            miscompares++;
            $display("FAIL wrap_next: got pc %h pc4 %h fault %b want 0 4 0", instr_pc, instr_pc4, fetch_fault);
        end
    endtask

    task automatic test_fault();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_000A;
        step();
        vectors++;
        if ({fetch_fault, instr_valid, imem_addr} !== {1'b1, 1'b0, 32'h0000_000A}) begin
            miscompares++;
            $display("FAIL fault_entry: got fault %b valid %b addr %h want 1 0 a", fetch_fault, instr_valid, imem_addr);
        end
        redirect_pc = 32'd0;
        for (int i = 0; i < 4; i++) begin
            instr_ready = 1'($urandom_range(0, 1));
            step();
            vectors++;
            if ({fetch_fault, instr_valid, imem_addr} !== {1'b1, 1'b0, 32'h0000_000A} || dut_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL fault_sticky[%0d]: got %h want %h", i, dut_vec(), model_vec());
            end
        end
        redirect_valid = 1'b0;
        instr_ready = 1'b1;
        rst = 1'b1;
        #2;
        model_reset();
        vectors++;
        if ({fetch_fault, instr_valid, imem_addr} !== {1'b0, 1'b0, 32'd0}) begin
            miscompares++;
            $display("FAIL fault_clear: got fault %b valid %b addr %h want 0 0 0", fetch_fault, instr_valid, imem_addr);
        end
        rst = 1'b0;
    endtask

    task automatic test_async_reset();
        instr_ready = 1'b1;
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        vectors++;
        if (dut_vec() !== 130'd0) begin
            miscompares++;
            $display("FAIL async_reset: got %h want %h", dut_vec(), 130'd0);
        end
        #2;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            vectors++;
            if (instr_pc !== 32'(4 * i) || dut_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL async_resume[%0d]: got %h want %h", i, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] tgt;
        for (int i = 0; i < 400; i++) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 7) == 0);
            tgt = $urandom_range(0, 63) * 4;
            if ($urandom_range(0, 19) == 0) tgt = tgt | 32'($urandom_range(1, 3));
            redirect_pc = tgt;
            step();
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL random[%0d]: got %h want %h", i, dut_vec(), model_vec());
            end
            if (m_fault) begin
                rst = 1'b1;
                #2;
                rst = 1'b0;
                model_reset();
            end
        end
        redirect_valid = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        model_reset();
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_fault();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
